// File: rtl/mmio_uart_transmitter.sv
// Memory-mapped UART transmitter on the data-side load/store bus.
// Stored bytes queue in a TX FIFO and leave on uart_tx as 8N1 frames.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   subfunction_3       funct3 of the current load/store
//   effective_address   byte address of the access
//   store_data          store source; only [7:0] is transmitted
//   opcode_is_store/ld  current instruction kind
//   io_hit              address falls in the 16-byte register window
//   clk_stall           core must hold the current instruction
//   load_error          bad funct3 or misaligned load in the window
//   store_error         bad funct3, misaligned, or read-only target
//   result_to_write_rd  load result, registered
//   uart_tx             serial line, idle high
module mmio_uart_transmitter #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h00002000,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          CLOCKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  subfunction_3,
  input  logic [31:0] effective_address,
  input  logic [31:0] store_data,
  input  logic        opcode_is_store,
  input  logic        opcode_is_load,
  output logic        io_hit,
  output logic        clk_stall,
  output logic        load_error,
  output logic        store_error,
  output logic [31:0] result_to_write_rd,
  output logic        uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLOCKS_PER_BIT > 2) ?
                      $clog2(CLOCKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Bus-side state
  logic        clk_stall_q, clk_stall_d;
  logic        read_pending_q, read_pending_d;
  logic        write_pending_q, write_pending_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [31:0] snap_q, snap_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] result_q, result_d;

  // FIFO state
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Transmit state
  state_t      state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic        push;
  logic [7:0]  push_byte;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tx_busy;
  logic [31:0] status_word;
  logic [1:0]  reg_sel;
  logic        mis_h;
  logic        mis_w;
  logic        ld_bad;
  logic        st_bad;
  logic        load_go;
  logic        store_go;
  logic        bit_last;
  logic        unused_ok;

  assign unused_ok = ^store_data[31:8];

  assign io_hit  = effective_address[31:4] == BASE_ADDRESS[31:4];
  assign reg_sel = effective_address[3:2];
  assign mis_h   = effective_address[0];
  assign mis_w   = |effective_address[1:0];

  assign fifo_full  = count_q == CW'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  assign tx_busy    = state_q != IDLE;

  assign status_word = {16'b0, 8'(count_q), 5'b0,
                        fifo_empty, fifo_full, tx_busy};

  always_comb begin
    ld_bad = 1'b0;
    case (subfunction_3)
      3'b000, 3'b100: ld_bad = 1'b0;
      3'b001, 3'b101: ld_bad = mis_h;
      3'b010:         ld_bad = mis_w;
      default:        ld_bad = 1'b1;
    endcase
  end

  // Only TXDATA is writable.
  always_comb begin
    st_bad = 1'b0;
    case (subfunction_3)
      3'b000:  st_bad = 1'b0;
      3'b001:  st_bad = mis_h;
      3'b010:  st_bad = mis_w;
      default: st_bad = 1'b1;
    endcase
    if (reg_sel != 2'd0) st_bad = 1'b1;
  end

  assign load_error  = io_hit & opcode_is_load & ld_bad;
  assign store_error = io_hit & opcode_is_store & st_bad;

  assign load_go  = io_hit & opcode_is_load & ~ld_bad;
  assign store_go = io_hit & opcode_is_store &
                    ~opcode_is_load & ~st_bad;

  // Bus handshake
  always_comb begin
    push            = 1'b0;
    push_byte       = store_data[7:0];
    clk_stall_d     = clk_stall_q;
    read_pending_d  = read_pending_q;
    write_pending_d = write_pending_q;
    wbyte_d         = wbyte_q;
    snap_d          = snap_q;
    f3_d            = f3_q;
    result_d        = result_q;
    if (read_pending_q) begin
      clk_stall_d    = 1'b0;
      read_pending_d = 1'b0;
      case (f3_q)
        3'b000:  result_d = {{24{snap_q[7]}}, snap_q[7:0]};
        3'b100:  result_d = {24'b0, snap_q[7:0]};
        3'b001:  result_d = {{16{snap_q[15]}}, snap_q[15:0]};
        3'b101:  result_d = {16'b0, snap_q[15:0]};
        default: result_d = snap_q;
      endcase
    end else if (write_pending_q) begin
      // The held store was latched; wait for room, push once.
      if (!fifo_full) begin
        push            = 1'b1;
        push_byte       = wbyte_q;
        clk_stall_d     = 1'b0;
        write_pending_d = 1'b0;
      end
    end else if (load_go) begin
      clk_stall_d    = 1'b1;
      read_pending_d = 1'b1;
      f3_d           = subfunction_3;
      snap_d         = (reg_sel == 2'd1) ? status_word : 32'b0;
    end else if (store_go) begin
      if (!fifo_full) begin
        push = 1'b1;
      end else begin
        clk_stall_d     = 1'b1;
        write_pending_d = 1'b1;
        wbyte_d         = store_data[7:0];
      end
    end
  end

  // Transmit FSM
  assign bit_last = cnt_q == BW'(CLOCKS_PER_BIT - 1);

  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_last) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          cnt_d = '0;
          // Chain straight into the next start bit.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_byte;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_stall_q     <= 1'b0;
      read_pending_q  <= 1'b0;
      write_pending_q <= 1'b0;
      wbyte_q         <= '0;
      snap_q          <= '0;
      f3_q            <= '0;
      result_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      tx_q            <= 1'b1;
    end else begin
      clk_stall_q     <= clk_stall_d;
      read_pending_q  <= read_pending_d;
      write_pending_q <= write_pending_d;
      wbyte_q         <= wbyte_d;
      snap_q          <= snap_d;
      f3_q            <= f3_d;
      result_q        <= result_d;
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_q           <= bit_d;
      shift_q         <= shift_d;
      tx_q            <= tx_d;
    end
  end

  assign clk_stall          = clk_stall_q;
  assign result_to_write_rd = result_q;
  assign uart_tx            = tx_q;

endmodule

// File: tb/tb_mmio_uart_transmitter.sv
// Directed bench for mmio_uart_transmitter.
// A line monitor decodes frames against a queue of expected bytes.
module tb_mmio_uart_transmitter;

  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        is_st;
  logic        is_ld;
  logic        io_hit;
  logic        clk_stall;
  logic        load_error;
  logic        store_error;
  logic [31:0] result;
  logic        uart_tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_busy = 0;
  logic [7:0] sb [$];
  int starts [$];

  mmio_uart_transmitter #(
    .BASE_ADDRESS  (32'h00002000),
    .FIFO_DEPTH    (4),
    .CLOCKS_PER_BIT(CPB)
  ) dut (
    .clk               (clk),
    .reset_n           (rst_n),
    .subfunction_3     (f3),
    .effective_address (addr),
    .store_data        (wdata),
    .opcode_is_store   (is_st),
    .opcode_is_load    (is_ld),
    .io_hit            (io_hit),
    .clk_stall         (clk_stall),
    .load_error        (load_error),
    .store_error       (store_error),
    .result_to_write_rd(result),
    .uart_tx           (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ld, input bit st,
                       input logic [2:0] fn,
                       input logic [31:0] a,
                       input logic [31:0] d);
    is_ld = ld;
    is_st = st;
    f3    = fn;
    addr  = a;
    wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic do_load(input string tag,
                         input logic [31:0] a,
                         input logic [2:0] fn,
                         input logic [31:0] exp);
    drive(1'b1, 1'b0, fn, a, 32'h0);
    step();
    chk({tag, "_stall1"}, 32'(clk_stall), 32'd1);
    step();
    chk({tag, "_stall0"}, 32'(clk_stall), 32'd0);
    chk(tag, result, exp);
    idle();
  endtask

  // Store that must be accepted without a stall.
  task automatic do_store(input string tag,
                          input logic [2:0] fn,
                          input logic [31:0] d);
    drive(1'b0, 1'b1, fn, 32'h2000, d);
    sb.push_back(d[7:0]);
    step();
    chk({tag, "_nostall"}, 32'(clk_stall), 32'd0);
    idle();
  endtask

  task automatic wait_drain(input string tag, input int lim);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(n < lim), 32'd1);
  endtask

  // Line monitor: samples mid-bit on falling clock edges.
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        mon_busy = 1;
        starts.push_back(cyc);
        ok = 1;
        repeat (CPB / 2) @(negedge clk);
        if (rst_n !== 1'b1) ok = 0;
        if (ok) chk("mon_start", 32'(uart_tx), 32'd0);
        b = '0;
        for (int k = 0; k < 8; k++) begin
          if (!ok) break;
          repeat (CPB) @(negedge clk);
          if (rst_n !== 1'b1) ok = 0;
          else b[k] = uart_tx;
        end
        if (ok) begin
          repeat (CPB) @(negedge clk);
          if (rst_n !== 1'b1) ok = 0;
        end
        if (ok) begin
          chk("mon_stop", 32'(uart_tx), 32'd1);
          if (sb.size() == 0) begin
            chk("mon_unexpected", 32'(b), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("mon_byte", 32'(b), 32'(e));
          end
          repeat (CPB / 2 - 1) @(negedge clk);
        end
        mon_busy = 0;
      end
    end
  end

  initial begin : stim
    int n;
    int s0;
    bit low_seen;
    rst_n = 1'b0;
    idle();
    step();
    step();
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_stall", 32'(clk_stall), 32'd0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;

    do_load("rst_status", 32'h2004, 3'b010, 32'h0000_0004);

    // Address decode
    drive(1'b1, 1'b0, 3'b010, 32'h3004, 32'h0);
    #1;
    chk("miss_hit", 32'(io_hit), 32'd0);
    step();
    chk("miss_stall", 32'(clk_stall), 32'd0);
    idle();

    // Single byte and frame length
    do_store("sb_a5", 3'b000, 32'h0000_00A5);
    step();
    chk("sb_start", 32'(uart_tx), 32'd0);
    repeat (38) step();
    do_load("stat_stop", 32'h2004, 3'b010, 32'h0000_0005);
    do_load("stat_idle", 32'h2004, 3'b010, 32'h0000_0004);
    wait_drain("drain1", 200);

    // Backpressure
    step();
    starts.delete();
    do_store("bp0", 3'b000, 32'h0000_0011);
    step();
    for (int i = 0; i < 4; i++) begin
      do_store("bp_sw", 3'b010, 32'hDEAD_BE00 | 32'(8'h22 + i));
    end
    drive(1'b0, 1'b1, 3'b010, 32'h2000, 32'hCAFE_F066);
    sb.push_back(8'h66);
    step();
    chk("bp_stall", 32'(clk_stall), 32'd1);
    n = 0;
    while (clk_stall === 1'b1 && n < 100) begin
      step();
      n++;
    end
    idle();
    chk("bp_stall_len", 32'(n), 32'd36);
    do_load("bp_full", 32'h2004, 3'b010, 32'h0000_0403);
    wait_drain("drain2", 400);
    chk("bp_frames", 32'(starts.size()), 32'd6);
    for (int i = 0; i + 1 < starts.size(); i++) begin
      chk("bp_gap", 32'(starts[i+1] - starts[i]), 32'(10 * CPB));
    end

    // Status loads with 3 bytes queued
    step();
    do_store("st0", 3'b000, 32'h0000_0081);
    do_store("st1", 3'b001, 32'h0000_7E42);
    do_store("st2", 3'b000, 32'h0000_00C3);
    do_store("st3", 3'b010, 32'h1234_5618);
    do_load("lw_status", 32'h2004, 3'b010, 32'h0000_0301);
    do_load("lb_status", 32'h2004, 3'b000, 32'h0000_0001);
    do_load("lhu_status", 32'h2004, 3'b101, 32'h0000_0301);
    do_load("lw_txdata", 32'h2000, 3'b010, 32'h0);
    do_load("lw_rsvd", 32'h200C, 3'b010, 32'h0);

    // Error cases
    drive(1'b0, 1'b1, 3'b010, 32'h2002, 32'h0000_0077);
    #1;
    chk("sw_mis_err", 32'(store_error), 32'd1);
    step();
    chk("sw_mis_stall", 32'(clk_stall), 32'd0);
    drive(1'b1, 1'b0, 3'b001, 32'h2005, 32'h0);
    #1;
    chk("lh_mis_err", 32'(load_error), 32'd1);
    step();
    chk("lh_mis_stall", 32'(clk_stall), 32'd0);
    drive(1'b1, 1'b0, 3'b011, 32'h2004, 32'h0);
    #1;
    chk("ld_f3_err", 32'(load_error), 32'd1);
    step();
    drive(1'b0, 1'b1, 3'b000, 32'h2004, 32'h0000_0055);
    #1;
    chk("sb_ro_err", 32'(store_error), 32'd1);
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h2004, 32'h0);
    #1;
    chk("lw_ok_err", 32'(load_error), 32'd0);
    idle();
    do_load("err_count", 32'h2004, 3'b010, 32'h0000_0301);

    // Reset during data bit 3
    s0 = starts.size();
    n = 0;
    while (starts.size() == s0 && n < 100) begin
      step();
      n++;
    end
    chk("mid_found", 32'(n < 100), 32'd1);
    repeat (15) step();
    rst_n = 1'b0;
    sb.delete();
    step();
    chk("mid_rst_tx", 32'(uart_tx), 32'd1);
    repeat (3) step();
    rst_n = 1'b1;
    do_load("mid_status", 32'h2004, 3'b010, 32'h0000_0004);
    s0 = starts.size();
    low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (uart_tx !== 1'b1) low_seen = 1;
    end
    chk("mid_quiet", 32'(low_seen), 32'd0);
    chk("mid_nostart", 32'(starts.size()), 32'(s0));

    // Recovery after reset
    do_store("post", 3'b000, 32'h0000_003C);
    wait_drain("drain3", 200);
    do_load("end_status", 32'h2004, 3'b010, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
